// File: rtl/of_ex_stage_reg.sv
// Elastic OF->EX pipeline register: 2-entry skid buffer, flush, and bubble control masking.
// Optional stall/bubble performance counters are built when OF_EX_PERF_EN is defined.
module of_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 9,
  parameter int ALU_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [XLEN-1:0]   In_Instr,
  input  logic [XLEN-1:0]   In_Pc,
  input  logic [XLEN-1:0]   In_BranchTarget,
  input  logic [XLEN-1:0]   In_Op1,
  input  logic [XLEN-1:0]   In_Op2,
  input  logic [XLEN-1:0]   In_Immx,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [ALU_W-1:0]  In_AluSignal,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [XLEN-1:0]   Out_Instr,
  output logic [XLEN-1:0]   Out_Pc,
  output logic [XLEN-1:0]   Out_BranchTarget,
  output logic [XLEN-1:0]   Out_Op1,
  output logic [XLEN-1:0]   Out_Op2,
  output logic [XLEN-1:0]   Out_Immx,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [ALU_W-1:0]  Out_AluSignal,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  BubbleCount
);

  typedef struct packed {
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   bt;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   immx;
    logic [CTRL_W-1:0] ctrl;
    logic [ALU_W-1:0]  alu;
  } pld_t;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t state_q, state_d;
  pld_t   main_q, main_d, skid_q, skid_d, in_pld;
  logic   in_fire, out_fire;

  assign in_pld   = '{In_Instr, In_Pc, In_BranchTarget, In_Op1, In_Op2, In_Immx,
                      In_Ctrl, In_AluSignal};
  assign In_Ready  = (state_q != SKID);
  assign Out_Valid = (state_q != EMPTY);
  assign in_fire   = In_Valid & In_Ready;
  assign out_fire  = Out_Valid & Out_Ready;

  // Flush squashes everything, including a same-cycle input, but leaves payload intact.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d = FULL;
          main_d  = in_pld;
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_pld;
          end else if (in_fire) begin
            state_d = SKID;
            skid_d  = in_pld;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        SKID: if (out_fire) begin
          state_d = FULL;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign Out_Instr        = main_q.instr;
  assign Out_Pc           = main_q.pc;
  assign Out_BranchTarget = main_q.bt;
  assign Out_Op1          = main_q.op1;
  assign Out_Op2          = main_q.op2;
  assign Out_Immx         = main_q.immx;
  assign Out_Ctrl         = main_q.ctrl & {CTRL_W{Out_Valid}};
  assign Out_AluSignal    = main_q.alu;

`ifdef OF_EX_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

  // Saturating counters; they only ever clear on reset.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (Out_Valid && !Out_Ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (!Out_Valid && (bubble_q != '1))             bubble_d = bubble_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign StallCount  = stall_q;
  assign BubbleCount = bubble_q;
`else
  assign StallCount  = '0;
  assign BubbleCount = '0;
`endif

endmodule

// File: tb/tb_of_ex_stage_reg.sv
// Directed scoreboard bench for of_ex_stage_reg; payload fields are derived from the instruction word.
module tb_of_ex_stage_reg;
  localparam int XLEN = 32, CTRL_W = 9, ALU_W = 5, CNT_W = 4;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0, Flush = 1'b0, In_Valid = 1'b0, Out_Ready = 1'b1;
  logic              In_Ready, Out_Valid;
  logic [XLEN-1:0]   in_x = '0;
  logic [XLEN-1:0]   Out_Instr, Out_Pc, Out_BranchTarget, Out_Op1, Out_Op2, Out_Immx;
  logic [CTRL_W-1:0] Out_Ctrl;
  logic [ALU_W-1:0]  Out_AluSignal;
  logic [CNT_W-1:0]  StallCount, BubbleCount;

  int errors = 0, checks = 0;
  logic [XLEN-1:0] q[$];
  logic [XLEN-1:0] lm = '0;
  bit              lm_rst = 1'b1;
  int              m_stall = 0, m_bubble = 0;

  always #5 Clk = ~Clk;

  of_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .ALU_W(ALU_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Instr(in_x), .In_Pc(in_x << 2), .In_BranchTarget(in_x + 32'd100),
    .In_Op1(~in_x), .In_Op2(in_x ^ 32'h5a5a5a5a), .In_Immx(in_x * 32'd3),
    .In_Ctrl(in_x[CTRL_W-1:0]), .In_AluSignal(in_x[ALU_W-1:0]),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Instr(Out_Instr), .Out_Pc(Out_Pc), .Out_BranchTarget(Out_BranchTarget),
    .Out_Op1(Out_Op1), .Out_Op2(Out_Op2), .Out_Immx(Out_Immx),
    .Out_Ctrl(Out_Ctrl), .Out_AluSignal(Out_AluSignal),
    .StallCount(StallCount), .BubbleCount(BubbleCount)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare against the model, advance the model, then move to the next negedge.
  task automatic tick();
    logic [XLEN-1:0] h;
    bit v, inf, outf;
    v = (q.size() != 0);
    if (Reset_n) begin
      h = lm;
      chk("in_ready", {31'd0, In_Ready}, {31'd0, q.size() != 2});
      chk("out_valid", {31'd0, Out_Valid}, {31'd0, v});
      chk("out_instr", Out_Instr, lm_rst ? '0 : h);
      chk("out_pc", Out_Pc, lm_rst ? '0 : h << 2);
      chk("out_bt", Out_BranchTarget, lm_rst ? '0 : h + 32'd100);
      chk("out_op1", Out_Op1, lm_rst ? '0 : ~h);
      chk("out_op2", Out_Op2, lm_rst ? '0 : h ^ 32'h5a5a5a5a);
      chk("out_immx", Out_Immx, lm_rst ? '0 : h * 32'd3);
      chk("out_ctrl", {23'd0, Out_Ctrl}, (lm_rst || !v) ? '0 : {23'd0, h[8:0]});
      chk("out_alu", {27'd0, Out_AluSignal}, lm_rst ? '0 : {27'd0, h[4:0]});
      chk("stall_cnt", {28'd0, StallCount}, m_stall);
      chk("bubble_cnt", {28'd0, BubbleCount}, m_bubble);
    end
    inf  = In_Valid && (q.size() != 2);
    outf = v && Out_Ready;
    if (!Reset_n) begin
      q.delete(); lm = '0; lm_rst = 1'b1; m_stall = 0; m_bubble = 0;
    end else begin
`ifdef OF_EX_PERF_EN
      if (v && !Out_Ready && m_stall < 15) m_stall++;
      if (!v && m_bubble < 15) m_bubble++;
`endif
      if (Flush) q.delete();
      else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(in_x);
      end
      if (q.size() != 0) begin lm = q[0]; lm_rst = 1'b0; end
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drv(input bit vld, input logic [XLEN-1:0] x, input bit rdy);
    In_Valid = vld; in_x = x; Out_Ready = rdy;
    tick();
  endtask

  task automatic fill_skid();
    drv(1, 32'hA, 1);
    drv(1, 32'hB, 0);
    drv(1, 32'hD, 0);   // refused: stage is in SKID
  endtask

  initial begin
    @(negedge Clk);
    drv(0, 0, 1); drv(0, 0, 1);
    Reset_n = 1'b1;
    drv(0, 0, 1);
    for (int i = 1; i <= 4; i++) drv(1, i, 1);
    drv(0, 0, 1); drv(0, 0, 1);

    fill_skid();
    drv(0, 0, 0);
    drv(0, 0, 1); drv(0, 0, 1); drv(0, 0, 1);

    fill_skid();
    Flush = 1'b1; drv(1, 32'hC, 1);
    Flush = 1'b0; drv(0, 0, 1); drv(0, 0, 1);

    drv(1, 32'h1FF, 1);
    drv(0, 0, 1); drv(0, 0, 1);

    fill_skid();
    Reset_n = 1'b0; drv(0, 0, 0);
    Reset_n = 1'b1; drv(0, 0, 1);

    drv(1, 32'h77, 0);
    for (int i = 0; i < 20; i++) drv(0, 0, 0);
    drv(0, 0, 1); drv(0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      Flush = ($urandom_range(0, 15) == 0);
      drv($urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0);
    end
    Flush = 1'b0;
    drv(0, 0, 1); drv(0, 0, 1); drv(0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/of_ex_stage_reg.md
Name: of_ex_stage_reg

Overview:
- Parametrised, elastic OF→EX pipeline register for the RISC-32 core.
- Replaces the fixed negedge latch with a posedge register that has a valid/ready handshake and a 2-entry skid buffer.
- Adds flush (bubble injection) and masks control signals on bubbles, so the operand-fetch stage can stall or be squashed without losing or duplicating instructions.

Parameters:
- XLEN, 32, width of Instruction, PC, BranchTarget, Op1, Op2, Immx.
- CTRL_W, 9, width of control flag bundle {IsSt, IsLd, IsBeq, IsBgt, IsRet, IsImmediate, IsWb, IsUBranch, IsCall}; bit 0 = IsSt … bit 8 = IsCall.
- ALU_W, 5, width of AluSignal.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset_n  in  1  synchronous, active-low reset.
- Flush  in  1  squash all held entries (branch taken in EX).
- In_Valid  in  1  OF has a decoded instruction.
- In_Ready  out  1  stage can accept this cycle.
- In_Instr, In_Pc, In_BranchTarget, In_Op1, In_Op2, In_Immx  in  XLEN each  OF payload.
- In_Ctrl  in  CTRL_W  control flags.
- In_AluSignal  in  ALU_W  ALU opcode.
- Out_Valid  out  1  EX payload valid.
- Out_Ready  in  1  EX consumes this cycle.
- Out_Instr, Out_Pc, Out_BranchTarget, Out_Op1, Out_Op2, Out_Immx  out  XLEN each  registered payload.
- Out_Ctrl  out  CTRL_W  registered flags, forced 0 when Out_Valid=0.
- Out_AluSignal  out  ALU_W  registered ALU opcode.
- StallCount  out  CNT_W  cycles with Out_Valid=1 and Out_Ready=0.
- BubbleCount  out  CNT_W  cycles with Out_Valid=0.

Behaviour:
- Clock and reset: single clock Clk; reset synchronous, active-low (Reset_n sampled on posedge Clk).
- Reset: state EMPTY; main and skid payload registers = 0; Out_Valid=0; In_Ready=1 from the first cycle after reset; Out_Ctrl=0; counters=0. Reset mid-transfer discards all entries.
- Handshake events: in_fire = In_Valid & In_Ready; out_fire = Out_Valid & Out_Ready.
- In_Ready = (state != SKID). It depends only on registered state; there is no combinational path from Out_Ready.
- State EMPTY (main invalid):
  - in_fire → FULL; main ← In_*.
- State FULL (main valid, skid invalid):
  - in_fire & out_fire → FULL; main ← In_*.
  - in_fire & !out_fire → SKID; skid ← In_*.
  - !in_fire & out_fire → EMPTY.
  - Otherwise hold.
- State SKID (both valid):
  - out_fire → FULL; main ← skid.
  - Otherwise hold. No input is accepted.
- Outputs:
  - Out_Valid = (state != EMPTY).
  - Out_* = main registers; Out_Ctrl = main_ctrl & {CTRL_W{Out_Valid}}.
- Latency: 1 cycle from in_fire to Out_Valid. Throughput: 1 instruction/cycle while Out_Ready=1.
- Stability: while Out_Valid=1 and Out_Ready=0, all Out_* hold bit-stable.
- Ordering: strict FIFO; the skid entry is never presented before main.
- Flush: highest priority below reset. Next state = EMPTY regardless of in_fire/out_fire. A simultaneous input is discarded even though In_Ready=1; upstream treats it as squashed. Payload registers retain their values, but Out_Ctrl reads 0.
- Flush in SKID: both entries are dropped. In_Ready=1 on the next cycle.
- Data is never cleared except by reset.

Optional Feature:
- Macro OF_EX_PERF_EN.
- Defined:
  - StallCount increments each cycle with Out_Valid & !Out_Ready.
  - BubbleCount increments each cycle with !Out_Valid, excluding cycles in reset.
  - Both saturate at 2^CNT_W-1 and clear only on reset.
- Undefined: no counter registers are built; StallCount and BubbleCount are driven constant 0.

Test Plan:
- Reset then stream: Reset_n=0 for 2 cycles, then In_Valid=1 with Instr=0x00000001..0x00000004 on consecutive cycles, Out_Ready=1 → Out_Valid rises 1 cycle after the first accept; Out_Instr shows 1,2,3,4 back-to-back; In_Ready stays 1.
- Backpressure/skid: FULL holding Instr=0xA, Out_Ready=0, present Instr=0xB → SKID, In_Ready=0, Out_Instr holds 0xA. Raise Out_Ready → 0xA then 0xB appear on successive cycles; no loss, no duplication.
- Flush in SKID: state SKID (0xA, 0xB), Flush=1 with In_Valid=1 Instr=0xC → next cycle Out_Valid=0, Out_Ctrl=0, In_Ready=1. 0xC never appears on the output.
- Bubble masking: In_Ctrl=9'h1FF accepted and consumed, then In_Valid=0 → Out_Valid=0 and Out_Ctrl=0 while Out_Instr retains its last value.
- Reset mid-operation: SKID state, Reset_n=0 for 1 cycle → Out_Valid=0, all Out_* =0, In_Ready=1 the next cycle.
- Perf (OF_EX_PERF_EN defined, CNT_W=4): 20 cycles with Out_Valid=1 and Out_Ready=0 → StallCount saturates at 15. Without the macro, StallCount=0 throughout.
